// File: rtl/logic_unit_arbiter.sv
// Two requesters share one bitwise logic unit (AND/OR/XOR/NOR) through a
// round-robin arbiter feeding a single-entry result register.
module logic_unit_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             res_id,
   input  logic             res_ready,
   output logic             busy
);

   // Handshake: a transfer happens on any edge where valid && ready are both
   // high; ready may look at valid, valid never waits for ready, and the
   // producer must hold its payload until the transfer edge.

   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             res_id_q, res_id_d;
   logic             last_grant_q, last_grant_d;

   logic             can_accept;
   logic             grant1;
   logic             xfer;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [WIDTH-1:0] unit_out;

   function automatic logic [WIDTH-1:0] logic_op(input logic [1:0]       op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      case (op)
         2'b00:   r = a & b;
         2'b01:   r = a | b;
         2'b10:   r = a ^ b;
         default: r = ~(a | b);
      endcase
      return r;
   endfunction

   always_comb begin
      can_accept = !res_valid_q || res_ready;
      // On contention the requester not named by last_grant wins.
      grant1     = req1_valid && (!req0_valid || !last_grant_q);
      req0_ready = !reset && can_accept && req0_valid && !grant1;
      req1_ready = !reset && can_accept && grant1;
      xfer       = req0_ready || req1_ready;
      sel_op     = grant1 ? req1_op : req0_op;
      sel_a      = grant1 ? req1_a  : req0_a;
      sel_b      = grant1 ? req1_b  : req0_b;
      unit_out   = logic_op(sel_op, sel_a, sel_b);
   end

   always_comb begin
      res_valid_d  = res_valid_q;
      res_data_d   = res_data_q;
      res_id_d     = res_id_q;
      last_grant_d = last_grant_q;
      if (xfer) begin
         res_valid_d  = 1'b1;
         res_data_d   = unit_out;
         res_id_d     = grant1;
         last_grant_d = grant1;
      end else if (res_ready) begin
         res_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res_valid_q  <= 1'b0;
         res_data_q   <= '0;
         res_id_q     <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         res_valid_q  <= res_valid_d;
         res_data_q   <= res_data_d;
         res_id_q     <= res_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign busy      = res_valid_q || req0_valid || req1_valid;

endmodule
